decode_stage_p: RTL and testbench
=================================

# decode_stage_p

Parametrised RISC-V decode stage: next generation of the pipeline decoder, between fetch/icache and execute. Holds the integer register file with write-back bypass and generates the sign-extended immediate. Detects load-use hazards and inserts a configurable number of bubbles after control-transfer instructions. All results are captured in a pipeline register with an explicit valid bit.

## Interface
- XLEN, 32, datapath width; 32 or 64
- REG_COUNT, 32, architectural registers; 32 (RV32I) or 16 (RV32E); RA = $clog2(REG_COUNT)
- BRANCH_BUBBLES, 2, bubbles issued after an accepted branch/JAL/JALR; 0..7

Reset is synchronous and active-high; single clock.

- clk  in  1  clock, all state on rising edge
- rst_h  in  1  synchronous active-high reset
- valid_from_fetch  in  1  instr_from_icache/pc_from_fetch are meaningful
- pc_from_fetch  in  XLEN  PC of presented instruction
- instr_from_icache  in  32  instruction word
- write_reg_from_write_back  in  1  register write enable
- rd_from_write_back  in  RA  write index
- write_data_from_write_back  in  XLEN  write data
- flush_from_execute  in  1  taken branch resolved; kill decode
- stall_fetch_from_decoder  out  1  fetch must hold PC and instruction (combinational)
- valid_from_decoder  out  1  pipeline register holds a real instruction
- pc_from_decoder, rs1_data_from_decoder, rs2_data_from_decoder, imm_from_decoder  out  XLEN each
- rs1_from_decoder, rs2_from_decoder, rd_from_decoder  out  RA each
- opcode_from_decoder  out  7;  funct3_from_decoder  out  3;  funct7b5_from_decoder  out  1 (instr[30])

## Operation
- Register file: REG_COUNT x XLEN; index 0 reads 0, writes to index 0 ignored; write when write_reg_from_write_back.
- Bypass: read index equal to rd_from_write_back (nonzero) with write enabled in the same cycle returns write_data_from_write_back.
- Register fields instr[19:15], [24:20], [11:7] truncated to low RA bits.
- Immediate by opcode: I (0000011, 0010011, 1100111), S (0100011), B (1100011), U (0110111, 0010111), J (1101111); sign-extended from instr[31] to XLEN; any other opcode -> 0.
- rs1 used by all opcodes except LUI, AUIPC, JAL; rs2 used only by 0110011, 0100011, 1100011.
- Load-use hazard: pipeline register valid, opcode 0000011, rd != 0, and a used source index of the presented valid instruction equals that rd.
- Bubble: valid_from_decoder = 0 and every other output = 0.
- Bubble counter (3 bits): loaded with BRANCH_BUBBLES when a valid 1100011/1101111/1100111 is captured; decrements by 1 per cycle while nonzero.
- Per-cycle priority, highest first:
  - rst_h: bubble; counter = 0; all registers = 0.
  - flush_from_execute: bubble; counter = 0; no stall.
  - counter != 0: bubble; stall asserted.
  - load-use: bubble; stall asserted; same instruction re-decoded next cycle.
  - valid_from_fetch = 0: bubble; no stall.
  - Otherwise: capture decoded instruction, valid = 1.
- Register file writes proceed in every case except rst_h.

## Timing
- Latency: one cycle, presented instruction to registered outputs.
- stall_fetch_from_decoder: combinational from counter, pipeline register and current instruction; never asserted during rst_h or flush.
- Branch captured at edge N: stall and bubbles on cycles N+1..N+BRANCH_BUBBLES. With BRANCH_BUBBLES = 0 there is no stall.
- Load-use: exactly one bubble; cannot repeat, since the bubble clears the load from the pipeline register.
- Flush during counter: counter cleared at that edge; the next cycle decodes normally.
- Reset values: all outputs 0; stall_fetch_from_decoder 0; register file all 0 after one rst_h cycle.

## Test plan
- Write x5 = 0x1234 via write-back, then ADDI x6,x5,-1 (0xFFF28313) -> next cycle rs1_data = 0x1234, imm = 0xFFFFFFFF, rd = 6, valid = 1.
- Write-back x7 = 0xCAFE in the same cycle ADD x8,x7,x7 is presented -> rs1_data = rs2_data = 0xCAFE (bypass); write to x0 -> x0 reads 0.
- LW x9,0(x1), then ADD x10,x9,x2 -> one cycle with stall = 1 and bubble, then ADD captured valid; same with rd = x0 -> no stall.
- BEQ (BRANCH_BUBBLES = 2) -> stall high exactly 2 cycles with bubbles; BRANCH_BUBBLES = 0 -> no stall.
- flush_from_execute on the first bubble cycle after JAL -> counter cleared, next valid instruction captured the following cycle.
- rst_h mid-stall with REG_COUNT = 16 -> all outputs 0, stall 0; instruction rs1 = x17 decodes as x1.

Source files
------------

// File: rtl/decode_stage_p.sv
// RISC-V decode stage: integer register file with write-back bypass, immediate
// generation, load-use interlock and post-control-transfer bubble insertion.
module decode_stage_p #(
   parameter  int XLEN           = 32,
   parameter  int REG_COUNT      = 32,
   parameter  int BRANCH_BUBBLES = 2,
   localparam int RA             = $clog2(REG_COUNT)
) (
   input  logic            clk,
   input  logic            rst_h,
   input  logic            valid_from_fetch,
   input  logic [XLEN-1:0] pc_from_fetch,
   input  logic [31:0]     instr_from_icache,
   input  logic            write_reg_from_write_back,
   input  logic [RA-1:0]   rd_from_write_back,
   input  logic [XLEN-1:0] write_data_from_write_back,
   input  logic            flush_from_execute,
   output logic            stall_fetch_from_decoder,
   output logic            valid_from_decoder,
   output logic [XLEN-1:0] pc_from_decoder,
   output logic [XLEN-1:0] rs1_data_from_decoder,
   output logic [XLEN-1:0] rs2_data_from_decoder,
   output logic [XLEN-1:0] imm_from_decoder,
   output logic [RA-1:0]   rs1_from_decoder,
   output logic [RA-1:0]   rs2_from_decoder,
   output logic [RA-1:0]   rd_from_decoder,
   output logic [6:0]      opcode_from_decoder,
   output logic [2:0]      funct3_from_decoder,
   output logic            funct7b5_from_decoder
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [RA-1:0]   rs1;
      logic [RA-1:0]   rs2;
      logic [RA-1:0]   rd;
      logic [6:0]      opcode;
      logic [2:0]      funct3;
      logic            funct7b5;
   } dec_t;

   dec_t            dec_q, dec_d, dec_new;
   logic [2:0]      bub_cnt_q, bub_cnt_d;
   logic [XLEN-1:0] rf_q [REG_COUNT];

   logic [6:0]         opcode;
   logic [RA-1:0]      rs1, rs2;
   logic signed [31:0] imm32;
   logic [XLEN-1:0]    rs1_data, rs2_data;
   logic               use_rs1, use_rs2, is_cti, load_use, stall;

   assign opcode = instr_from_icache[6:0];
   assign rs1    = instr_from_icache[15 +: RA];
   assign rs2    = instr_from_icache[20 +: RA];

   // A same-cycle write-back to the read index wins over the stored value.
   assign rs1_data = (rs1 == '0) ? '0 :
                     (write_reg_from_write_back && rd_from_write_back == rs1) ?
                     write_data_from_write_back : rf_q[rs1];
   assign rs2_data = (rs2 == '0) ? '0 :
                     (write_reg_from_write_back && rd_from_write_back == rs2) ?
                     write_data_from_write_back : rf_q[rs2];

   always_comb begin
      imm32 = '0;
      case (opcode)
         OP_LOAD, OP_IMM, OP_JALR:
            imm32 = {{20{instr_from_icache[31]}}, instr_from_icache[31:20]};
         OP_STORE:
            imm32 = {{20{instr_from_icache[31]}}, instr_from_icache[31:25],
                     instr_from_icache[11:7]};
         OP_BRANCH:
            imm32 = {{19{instr_from_icache[31]}}, instr_from_icache[31],
                     instr_from_icache[7], instr_from_icache[30:25],
                     instr_from_icache[11:8], 1'b0};
         OP_LUI, OP_AUIPC:
            imm32 = {instr_from_icache[31:12], 12'b0};
         OP_JAL:
            imm32 = {{11{instr_from_icache[31]}}, instr_from_icache[31],
                     instr_from_icache[19:12], instr_from_icache[20],
                     instr_from_icache[30:21], 1'b0};
         default: imm32 = '0;
      endcase
   end

   always_comb begin
      dec_new          = '0;
      dec_new.valid    = 1'b1;
      dec_new.pc       = pc_from_fetch;
      dec_new.rs1_data = rs1_data;
      dec_new.rs2_data = rs2_data;
      dec_new.imm      = XLEN'(imm32);
      dec_new.rs1      = rs1;
      dec_new.rs2      = rs2;
      dec_new.rd       = instr_from_icache[7 +: RA];
      dec_new.opcode   = opcode;
      dec_new.funct3   = instr_from_icache[14:12];
      dec_new.funct7b5 = instr_from_icache[30];
   end

   assign use_rs1 = !(opcode inside {OP_LUI, OP_AUIPC, OP_JAL});
   assign use_rs2 = opcode inside {OP_REG, OP_STORE, OP_BRANCH};
   assign is_cti  = opcode inside {OP_BRANCH, OP_JAL, OP_JALR};

   assign load_use = dec_q.valid && dec_q.opcode == OP_LOAD && dec_q.rd != '0 &&
                     valid_from_fetch &&
                     ((use_rs1 && rs1 == dec_q.rd) || (use_rs2 && rs2 == dec_q.rd));

   always_comb begin
      dec_d     = '0;
      bub_cnt_d = bub_cnt_q;
      stall     = 1'b0;
      if (rst_h || flush_from_execute) begin
         bub_cnt_d = '0;
      end else if (bub_cnt_q != '0) begin
         bub_cnt_d = bub_cnt_q - 3'd1;
         stall     = 1'b1;
      end else if (load_use) begin
         stall = 1'b1;
      end else if (valid_from_fetch) begin
         dec_d = dec_new;
         if (is_cti) bub_cnt_d = 3'(BRANCH_BUBBLES);
      end
   end

   assign stall_fetch_from_decoder = stall;

   // NOTE: the register file shares the synchronous reset, so every entry reads 0 after one rst_h cycle.
   always_ff @(posedge clk) begin
      if (rst_h) begin
         dec_q     <= '0;
         bub_cnt_q <= '0;
         for (int i = 0; i < REG_COUNT; i++) rf_q[i] <= '0;
      end else begin
         dec_q     <= dec_d;
         bub_cnt_q <= bub_cnt_d;
         if (write_reg_from_write_back && rd_from_write_back != '0)
            rf_q[rd_from_write_back] <= write_data_from_write_back;
      end
   end

   assign valid_from_decoder    = dec_q.valid;
   assign pc_from_decoder       = dec_q.pc;
   assign rs1_data_from_decoder = dec_q.rs1_data;
   assign rs2_data_from_decoder = dec_q.rs2_data;
   assign imm_from_decoder      = dec_q.imm;
   assign rs1_from_decoder      = dec_q.rs1;
   assign rs2_from_decoder      = dec_q.rs2;
   assign rd_from_decoder       = dec_q.rd;
   assign opcode_from_decoder   = dec_q.opcode;
   assign funct3_from_decoder   = dec_q.funct3;
   assign funct7b5_from_decoder = dec_q.funct7b5;

endmodule

// File: tb/tb_decode_stage_p.sv
// Bench for decode_stage_p: three configurations (default, no bubbles, RV32E)
// share one stimulus stream and are compared against a behavioural model.
module tb_decode_stage_p;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] rs1d;
      logic [31:0] rs2d;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic        f7;
   } exp_t;

   logic        clk;
   logic        rst_h, flush, vff, we;
   logic [31:0] pc, instr, wb_data;
   logic [4:0]  wb_rd;

   exp_t obs [3];
   logic stall_o [3];

   int cfg_rc [3] = '{32, 32, 16};
   int cfg_bb [3] = '{2, 0, 2};

   exp_t        m_out [3];
   int          m_cnt [3];
   logic [31:0] m_rf  [3][32];

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int RC = (g == 2) ? 16 : 32;
      localparam int BB = (g == 1) ? 0 : 2;
      localparam int RA = $clog2(RC);
      logic          v, st, f7;
      logic [31:0]   pco, d1, d2, im;
      logic [RA-1:0] r1, r2, rdo;
      logic [6:0]    op;
      logic [2:0]    f3;

      decode_stage_p #(.XLEN(32), .REG_COUNT(RC), .BRANCH_BUBBLES(BB)) u_dut (
         .clk                        (clk),
         .rst_h                      (rst_h),
         .valid_from_fetch           (vff),
         .pc_from_fetch              (pc),
         .instr_from_icache          (instr),
         .write_reg_from_write_back  (we),
         .rd_from_write_back         (wb_rd[RA-1:0]),
         .write_data_from_write_back (wb_data),
         .flush_from_execute         (flush),
         .stall_fetch_from_decoder   (st),
         .valid_from_decoder         (v),
         .pc_from_decoder            (pco),
         .rs1_data_from_decoder      (d1),
         .rs2_data_from_decoder      (d2),
         .imm_from_decoder           (im),
         .rs1_from_decoder           (r1),
         .rs2_from_decoder           (r2),
         .rd_from_decoder            (rdo),
         .opcode_from_decoder        (op),
         .funct3_from_decoder        (f3),
         .funct7b5_from_decoder      (f7)
      );

      assign obs[g]     = {v, pco, d1, d2, im, 5'(r1), 5'(r2), 5'(rdo), op, f3, f7};
      assign stall_o[g] = st;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [154:0] got, input logic [154:0] want);
      n_total++;
      assert (got === want) n_pass++;
      else $error("FAIL %s got=%h want=%h", tag, got, want);
   endtask

   // Immediate formats rebuilt with signed arithmetic shifts.
   function automatic logic [31:0] imm_of(input logic [31:0] i);
      logic signed [31:0] s;
      s = i;
      case (i[6:0])
         7'b0000011, 7'b0010011, 7'b1100111: return 32'(s >>> 20);
         7'b0100011: return 32'((s >>> 25) << 5) | 32'(i[11:7]);
         7'b1100011: return 32'((s >>> 31) << 12) | (32'(i[7]) << 11) |
                            (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
         7'b0110111, 7'b0010111: return i & 32'hFFFF_F000;
         7'b1101111: return 32'((s >>> 31) << 20) | (32'(i[19:12]) << 12) |
                            (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] reg_val(input int c, input int idx);
      if (idx == 0) return 32'd0;
      if (we && (int'(wb_rd) % cfg_rc[c]) == idx) return wb_data;
      return m_rf[c][idx];
   endfunction

   function automatic bit hazard(input int c);
      int  r1, r2, prd;
      bit  u1, u2;
      r1  = int'(instr[19:15]) % cfg_rc[c];
      r2  = int'(instr[24:20]) % cfg_rc[c];
      prd = int'(m_out[c].rd);
      u1  = !(instr[6:0] inside {7'b0110111, 7'b0010111, 7'b1101111});
      u2  = instr[6:0] inside {7'b0110011, 7'b0100011, 7'b1100011};
      return m_out[c].valid && m_out[c].op == 7'b0000011 && prd != 0 && vff &&
             ((u1 && r1 == prd) || (u2 && r2 == prd));
   endfunction

   function automatic logic exp_stall(input int c);
      return !rst_h && !flush && (m_cnt[c] != 0 || hazard(c));
   endfunction

   task automatic model_edge(input int c);
      exp_t nx;
      int   w;
      nx       = '0;
      nx.valid = 1'b1;
      nx.pc    = pc;
      nx.rs1d  = reg_val(c, int'(instr[19:15]) % cfg_rc[c]);
      nx.rs2d  = reg_val(c, int'(instr[24:20]) % cfg_rc[c]);
      nx.imm   = imm_of(instr);
      nx.rs1   = 5'(int'(instr[19:15]) % cfg_rc[c]);
      nx.rs2   = 5'(int'(instr[24:20]) % cfg_rc[c]);
      nx.rd    = 5'(int'(instr[11:7]) % cfg_rc[c]);
      nx.op    = instr[6:0];
      nx.f3    = instr[14:12];
      nx.f7    = instr[30];
      if (rst_h) begin
         m_out[c] = '0;
         m_cnt[c] = 0;
         for (int i = 0; i < 32; i++) m_rf[c][i] = 32'd0;
         return;
      end
      if (flush) begin
         m_out[c] = '0;
         m_cnt[c] = 0;
      end else if (m_cnt[c] > 0) begin
         m_out[c] = '0;
         m_cnt[c] = m_cnt[c] - 1;
      end else if (hazard(c) || !vff) begin
         m_out[c] = '0;
      end else begin
         m_out[c] = nx;
         if (instr[6:0] inside {7'b1100011, 7'b1101111, 7'b1100111}) m_cnt[c] = cfg_bb[c];
      end
      w = int'(wb_rd) % cfg_rc[c];
      if (we && w != 0) m_rf[c][w] = wb_data;
   endtask

   // One clock: stall checked mid-cycle, model advanced at the edge, outputs checked just after.
   task automatic step();
      @(negedge clk);
      for (int c = 0; c < 3; c++)
         check($sformatf("stall[%0d] cyc %0d", c, cyc), 155'(stall_o[c]), 155'(exp_stall(c)));
      @(posedge clk);
      for (int c = 0; c < 3; c++) model_edge(c);
      #1;
      for (int c = 0; c < 3; c++)
         check($sformatf("out[%0d] cyc %0d", c, cyc), obs[c], m_out[c]);
      cyc++;
   endtask

   task automatic present(input logic [31:0] i, input logic [31:0] p);
      vff   = 1'b1;
      instr = i;
      pc    = p;
   endtask

   logic [6:0] ops [11] = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011, 7'b1100011,
                            7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b0000011,
                            7'b1111111};

   initial begin
      for (int c = 0; c < 3; c++) begin
         m_out[c] = '0;
         m_cnt[c] = 0;
         for (int i = 0; i < 32; i++) m_rf[c][i] = 32'd0;
      end
      rst_h = 1'b1; flush = 1'b0; vff = 1'b0; we = 1'b0;
      pc = '0; instr = '0; wb_rd = '0; wb_data = '0;
      step();
      step();
      check("reset_out", obs[0], '0);
      check("reset_stall", 155'(stall_o[0]), 155'(0));
      rst_h = 1'b0;

      // x5 = 0x1234, then ADDI x6,x5,-1
      we = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234;
      step();
      we = 1'b0;
      present(32'hFFF2_8313, 32'h100);
      step();
      check("addi_rs1d", 155'(obs[0].rs1d), 155'(32'h1234));
      check("addi_imm", 155'(obs[0].imm), 155'(32'hFFFF_FFFF));
      check("addi_rd", 155'(obs[0].rd), 155'(6));
      check("addi_valid", 155'(obs[0].valid), 155'(1));

      // bypass: x7 written while ADD x8,x7,x7 decodes
      we = 1'b1; wb_rd = 5'd7; wb_data = 32'hCAFE;
      present(32'h0073_8433, 32'h104);
      step();
      check("bypass_rs1", 155'(obs[0].rs1d), 155'(32'hCAFE));
      check("bypass_rs2", 155'(obs[0].rs2d), 155'(32'hCAFE));

      // write to x0 is dropped
      wb_rd = 5'd0; wb_data = 32'hDEAD;
      present(32'h0000_0433, 32'h108);
      step();
      we = 1'b0;
      step();
      check("x0_reads_zero", 155'(obs[0].rs1d), 155'(0));

      // load-use: LW x9,0(x1); ADD x10,x9,x2
      present(32'h0000_A483, 32'h10C);
      step();
      present(32'h0024_8533, 32'h110);
      step();
      check("loaduse_bubble", 155'(obs[0].valid), 155'(0));
      step();
      check("loaduse_valid", 155'(obs[0].valid), 155'(1));
      check("loaduse_rd", 155'(obs[0].rd), 155'(10));

      // LW x0 then consumer of x0: no interlock
      present(32'h0000_A003, 32'h114);
      step();
      present(32'h0020_0533, 32'h118);
      step();
      check("lw_x0_nostall", 155'(obs[0].valid), 155'(1));

      // BEQ then straight-line code
      present(32'h0020_8463, 32'h11C);
      step();
      present(32'hFFF2_8313, 32'h120);
      step();
      step();
      step();
      step();

      // JAL, flush on first bubble cycle, then normal decode
      present(32'h0100_00EF, 32'h124);
      step();
      flush = 1'b1;
      present(32'hFFF2_8313, 32'h134);
      step();
      check("flush_bubble", 155'(obs[0].valid), 155'(0));
      flush = 1'b0;
      step();
      check("after_flush_valid", 155'(obs[0].valid), 155'(1));

      // reset while stalled after a branch; then rs1 = x17 on RV32E
      present(32'h0020_8463, 32'h138);
      step();
      rst_h = 1'b1;
      step();
      check("rst_stall_out", obs[0], '0);
      rst_h = 1'b0;
      present(32'h0058_8193, 32'h13C);
      step();
      check("rv32e_rs1", 155'(obs[2].rs1), 155'(1));
      check("rv32i_rs1", 155'(obs[0].rs1), 155'(17));

      // randomized traffic
      for (int k = 0; k < 400; k++) begin
         logic [31:0] ri;
         ri      = $urandom;
         ri[6:0] = ops[$urandom_range(0, 10)];
         if ($urandom_range(0, 1) == 1) begin
            ri[11:7]  = 5'($urandom_range(0, 3));
            ri[19:15] = 5'($urandom_range(0, 3));
            ri[24:20] = 5'($urandom_range(0, 3));
         end
         instr   = ri;
         pc      = $urandom;
         vff     = ($urandom_range(0, 3) != 0);
         we      = ($urandom_range(0, 1) == 1);
         wb_rd   = 5'($urandom_range(0, 31));
         wb_data = $urandom;
         flush   = ($urandom_range(0, 15) == 0);
         rst_h   = ($urandom_range(0, 99) == 0);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
